rgb_fade_ctrl: RTL and testbench
================================

Name: rgb_fade_ctrl

Overview:
- Sequencer that owns the three PWM inputs of the on-chip RGB LED current driver (RGB0PWM/RGB1PWM/RGB2PWM).
- Accepts colour commands over a valid/ready handshake and ramps each channel's duty linearly toward its target at a fixed step rate, or applies the target instantly.
- Generates glitch-free PWM for the driver and replaces ad-hoc free-running LED counters in top-level designs.

Parameters:
- FREQ, 8_000_000, clk frequency in Hz.
- PWM_BITS, 8, duty resolution per channel (N).
- STEP_HZ, 1000, fade step rate in Hz. DIV = FREQ/STEP_HZ; DIV >= 1 is required.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept a command.
- cmd_color  in  3*PWM_BITS  target duties; [N-1:0]=ch0, [2N-1:N]=ch1, [3N-1:2N]=ch2.
- cmd_instant  in  1  1 = jump directly to target, 0 = fade.
- pwm  out  3  to RGBnPWM; bit i drives channel i.
- busy  out  1  fade in progress.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst high at a clk edge):
  - state=IDLE; cur[i]=0, act[i]=0, tgt[i]=0; pwm_ctr=0; step_ctr=0.
  - pwm=000, busy=0, done=0.
  - cmd_ready=0 while rst is high. Commands are ignored during reset.
  - Reset mid-fade abandons the fade with no done pulse.
- PWM generation:
  - pwm_ctr counts 0..2^N-2, then wraps to 0 (period 2^N-1 cycles).
  - pwm[i] is registered: pwm[i] <= (pwm_ctr < act[i]).
  - Duty 0 gives constant low; duty 2^N-1 gives constant high.
  - act[i] <= cur[i] only in the cycle where pwm_ctr == 2^N-2 (the wrap). New duties therefore take effect at the next period start, with no partial periods.
- Handshake:
  - cmd_ready = (state==IDLE) && !rst.
  - A transfer occurs on a clk edge where cmd_valid && cmd_ready. cmd_color and cmd_instant are sampled at that edge only.
  - cmd_valid while not ready is held off; the controller has no queue.
- FSM:
  - IDLE, accept with cmd_instant=1, or with cmd_color equal to cur on all channels: cur <= cmd_color; done=1 next cycle; stay IDLE.
  - IDLE, accept otherwise: tgt <= cmd_color; step_ctr <= 0; go to FADE. busy=1 from the next cycle.
  - FADE, step tick: a tick is the cycle where step_ctr == DIV-1; step_ctr then wraps to 0, otherwise it increments. The first tick occurs DIV cycles after acceptance.
  - On each tick, every channel with cur[i] != tgt[i] moves by 1 toward tgt[i] (up or down). Channels are independent, so equal channels stay put.
  - Completion: the tick that makes all cur == tgt also returns state to IDLE. busy drops and done=1 in the cycle after that tick; cmd_ready is high in that same cycle.
  - Fade duration in cycles = DIV * max_i |tgt[i]-cur[i]|.
- Boundaries:
  - No wrap-around; cur stays within 0..2^N-1.
  - done and a new acceptance may coincide; done refers to the previous command.
  - cmd_valid held high continuously gives back-to-back commands, one per IDLE visit.
- Widths: step_ctr is clog2(DIV) bits (min 1); pwm_ctr is N bits.

Test Plan (FREQ=1000, STEP_HZ=100 so DIV=10; PWM_BITS=8):
- Reset then idle: rst for 2 cycles -> pwm=000, busy=0, cmd_ready=0 during reset and 1 after; no done pulse.
- Instant command: cmd_color={8'h00,8'hFF,8'h80}, instant=1 -> done pulses next cycle. After the next PWM wrap: pwm[2] constant 0, pwm[1] constant 1, pwm[0] high exactly 128 of every 255 cycles.
- Fade up: from all-0, cmd_color ch0=5, ch1=3, ch2=0, instant=0 -> busy for 50 cycles. ch1 stops at 3 after 30 cycles. done pulses exactly once, 51 cycles after acceptance. cmd_ready is low throughout the fade.
- Fade down/mixed: from ch0=5, ch1=3, ch2=0, command ch0=2, ch1=3, ch2=4 -> ch0 decrements and ch2 increments each tick; completes after 40 cycles.
- Reset mid-fade: assert rst 25 cycles into a fade -> next cycle all outputs are at reset values, no done pulse, and a subsequent command is accepted normally.
- Backpressure and no-op: hold cmd_valid high during a fade -> not accepted until the done cycle. A command equal to cur -> done next cycle, busy never asserted.

Source files
------------

// File: rtl/rgb_fade_ctrl.sv
// RGB LED PWM sequencer: accepts colour commands over valid/ready and drives the three
// driver PWM inputs, either jumping to the target duty or ramping one step per tick.
module rgb_fade_ctrl #(
   parameter int FREQ     = 8_000_000,
   parameter int PWM_BITS = 8,
   parameter int STEP_HZ  = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [3*PWM_BITS-1:0]   cmd_color,
   input  logic                    cmd_instant,
   output logic [2:0]              pwm,
   output logic                    busy,
   output logic                    done
);

   localparam int DIV = FREQ / STEP_HZ;
   localparam int SCW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PWM_BITS-1:0] PWM_LAST  = {{(PWM_BITS-1){1'b1}}, 1'b0};
   localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);
   localparam logic [SCW-1:0]      STEP_LAST = SCW'(DIV - 1);
   localparam logic [SCW-1:0]      STEP_ONE  = SCW'(1);

   typedef enum logic {IDLE, FADE} state_t;

   state_t                     state_q, state_d;
   logic [2:0][PWM_BITS-1:0]   cur_q, cur_d;
   logic [2:0][PWM_BITS-1:0]   tgt_q, tgt_d;
   logic [2:0][PWM_BITS-1:0]   act_q, act_d;
   logic [2:0][PWM_BITS-1:0]   stepped;
   logic [PWM_BITS-1:0]        pwmCtr_q, pwmCtr_d;
   logic [SCW-1:0]             stepCtr_q, stepCtr_d;
   logic [2:0]                 pwm_q, pwm_d;
   logic                       done_q, done_d;
   logic                       accept;
   logic                       tick;
   logic                       pwmWrap;

   assign cmd_ready = (state_q == IDLE) && !rst;
   assign accept    = cmd_valid && cmd_ready;
   assign tick      = (stepCtr_q == STEP_LAST);
   assign pwmWrap   = (pwmCtr_q == PWM_LAST);
   assign busy      = (state_q == FADE);
   assign pwm       = pwm_q;
   assign done      = done_q;

   // Each channel independently moves one duty step toward its own target.
   always_comb begin
      stepped = cur_q;
      for (int i = 0; i < 3; i++) begin
         if (cur_q[i] < tgt_q[i]) begin
            stepped[i] = cur_q[i] + DUTY_ONE;
         end else if (cur_q[i] > tgt_q[i]) begin
            stepped[i] = cur_q[i] - DUTY_ONE;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      tgt_d     = tgt_q;
      stepCtr_d = stepCtr_q;
      done_d    = 1'b0;
      pwmCtr_d  = pwmWrap ? '0 : pwmCtr_q + DUTY_ONE;
      // Duties are only picked up at the period wrap so no period is ever cut short.
      act_d     = pwmWrap ? cur_q : act_q;
      for (int i = 0; i < 3; i++) begin
         pwm_d[i] = (pwmCtr_q < act_q[i]);
      end

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (cmd_instant || (cmd_color == cur_q)) begin
                  cur_d  = cmd_color;
                  done_d = 1'b1;
               end else begin
                  tgt_d     = cmd_color;
                  stepCtr_d = '0;
                  state_d   = FADE;
               end
            end
         end
         FADE: begin
            if (tick) begin
               stepCtr_d = '0;
               cur_d     = stepped;
               if (stepped == tgt_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               stepCtr_d = stepCtr_q + STEP_ONE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cur_q     <= '0;
         tgt_q     <= '0;
         act_q     <= '0;
         pwmCtr_q  <= '0;
         stepCtr_q <= '0;
         pwm_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_q     <= cur_d;
         tgt_q     <= tgt_d;
         act_q     <= act_d;
         pwmCtr_q  <= pwmCtr_d;
         stepCtr_q <= stepCtr_d;
         pwm_q     <= pwm_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Scoreboard bench for rgb_fade_ctrl: stimulus queues the expected completion of each
// command, a negedge monitor matches done pulses against it; PWM duty is measured directly.
module tb_rgb_fade_ctrl;

   localparam int N = 8;

   typedef struct {
      int lat;
      int busyCycles;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [3*N-1:0] cmd_color;
   logic          cmd_instant;
   logic [2:0]    pwm;
   logic          busy;
   logic          done;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   busyCnt = 0;
   int   rdyBusy = 0;
   exp_t expQ[$];
   int   accQ[$];
   exp_t monE;
   int   monA;
   logic dAcc;

   rgb_fade_ctrl #(
      .FREQ(1000),
      .PWM_BITS(N),
      .STEP_HZ(100)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_color(cmd_color),
      .cmd_instant(cmd_instant),
      .pwm(pwm),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input int actv, input int expv);
      total++;
      if (actv != expv) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actv, expv);
      end
   endtask

   // Queue the expected completion, then hold the command until it is accepted.
   task automatic applyStimulus(input logic [3*N-1:0] color, input logic instant,
                                input int lat, input int busyCyc, output logic doneAtAcc);
      exp_t e;
      bit   ok;
      e.lat = lat;
      e.busyCycles = busyCyc;
      expQ.push_back(e);
      cmd_color   = color;
      cmd_instant = instant;
      cmd_valid   = 1'b1;
      ok          = 1'b0;
      doneAtAcc   = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1'b1;
            doneAtAcc = done;
         end
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      if (!ok) begin
         total++;
         bad++;
         $display("[TB] FAIL accept_timeout: got not-accepted expected accepted");
      end
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while (expQ.size() != 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (expQ.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL %s_timeout: got %0d pending expected 0", tag, expQ.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic measurePwm(input string tag, input int e0, input int e1, input int e2);
      int c0 = 0;
      int c1 = 0;
      int c2 = 0;
      repeat (520) @(posedge clk);
      repeat (255) begin
         @(negedge clk);
         c0 += int'(pwm[0]);
         c1 += int'(pwm[1]);
         c2 += int'(pwm[2]);
      end
      checkOutput({tag, "_ch0_high"}, c0, e0);
      checkOutput({tag, "_ch1_high"}, c1, e1);
      checkOutput({tag, "_ch2_high"}, c2, e2);
      @(posedge clk);
      #1;
   endtask

   // Monitor: completes one scoreboard entry per done pulse, tracks busy per command.
   always @(negedge clk) begin
      if (rst) begin
         expQ.delete();
         accQ.delete();
         busyCnt = 0;
         rdyBusy = 0;
      end else begin
         if (done) begin
            if (expQ.size() == 0 || accQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_done: got done=1 expected done=0");
            end else begin
               monE = expQ.pop_front();
               monA = accQ.pop_front();
               checkOutput("done_latency", cyc - monA, monE.lat);
               checkOutput("busy_cycles", busyCnt, monE.busyCycles);
               checkOutput("ready_while_busy", rdyBusy, 0);
               checkOutput("busy_at_done", int'(busy), 0);
               checkOutput("ready_at_done", int'(cmd_ready), 1);
            end
         end
         if (cmd_valid && cmd_ready) begin
            accQ.push_back(cyc);
            busyCnt = 0;
            rdyBusy = 0;
         end
         if (busy) begin
            busyCnt++;
            if (cmd_ready) rdyBusy++;
         end
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst         = 1'b1;
      cmd_valid   = 1'b0;
      cmd_color   = '0;
      cmd_instant = 1'b0;

      @(negedge clk);
      checkOutput("ready_in_rst", int'(cmd_ready), 0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_pwm", int'(pwm), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("ready_in_rst2", int'(cmd_ready), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_rst", int'(cmd_ready), 1);
      checkOutput("done_after_rst", int'(done), 0);
      @(posedge clk);
      #1;

      $display("[TB] instant command");
      applyStimulus({8'h00, 8'hFF, 8'h80}, 1'b1, 1, 0, dAcc);
      waitIdle("instant");
      measurePwm("instant", 128, 255, 0);

      $display("[TB] fade up from zero");
      applyStimulus('0, 1'b1, 1, 0, dAcc);
      applyStimulus({8'd0, 8'd3, 8'd5}, 1'b0, 51, 50, dAcc);
      waitIdle("fade_up");
      measurePwm("fade_up", 5, 3, 0);

      $display("[TB] mixed fade");
      applyStimulus({8'd4, 8'd3, 8'd2}, 1'b0, 41, 40, dAcc);
      waitIdle("fade_mixed");
      measurePwm("fade_mixed", 2, 3, 4);

      $display("[TB] reset mid-fade");
      applyStimulus({8'd20, 8'd0, 8'd0}, 1'b0, 161, 160, dAcc);
      repeat (24) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("busy_before_rst", int'(busy), 1);
      checkOutput("ready_in_midrst", int'(cmd_ready), 0);
      @(posedge clk);
      @(negedge clk);
      checkOutput("midrst_pwm", int'(pwm), 0);
      checkOutput("midrst_busy", int'(busy), 0);
      checkOutput("midrst_done", int'(done), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      applyStimulus({8'd0, 8'd0, 8'd2}, 1'b0, 21, 20, dAcc);
      waitIdle("after_rst");

      $display("[TB] backpressure and no-op");
      applyStimulus({8'd0, 8'd0, 8'd5}, 1'b0, 31, 30, dAcc);
      applyStimulus({8'd0, 8'd0, 8'd5}, 1'b0, 1, 0, dAcc);
      checkOutput("done_with_accept", int'(dAcc), 1);
      waitIdle("backpressure");
      applyStimulus({8'd0, 8'd0, 8'd5}, 1'b0, 1, 0, dAcc);
      waitIdle("noop");
      measurePwm("final", 5, 0, 0);

      repeat (5) @(posedge clk);
      checkOutput("queue_empty", expQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
